bus_slave: RTL and testbench
============================

Name: bus_slave

Overview:
Serial-bus slave endpoint that consumes the master's serial outputs (control, wrD, valid, last) and produces its serial inputs (rD, ready).
- Decodes the serial control frame and matches it against its own SLAVE_ID.
- Executes single or burst writes and reads against a local word memory.
- Sits directly downstream of the bus master, behind the arbiter's bus mux; one instance per slave ID.

Parameters:
SLAVE_ID, 2'b01, 2-bit ID this instance answers to.
DATA_WIDTH, 16, bits per data word.
MEMORY_DEPTH, 4096, number of words in local memory.
ADDRESS_WIDTH, $clog2(MEMORY_DEPTH), address field width (12 by default).

Ports:
clk  input  1  system clock, all logic on rising edge.
rstN  input  1  asynchronous active-low reset.
control  input  1  serial control frame from master, idle low.
wrD  input  1  serial write data from master, MSB first.
valid  input  1  wrD bit is valid this cycle.
last  input  1  master marks final bit of final write word, or ends a burst read.
rD  output  1  serial read data to master, MSB first.
ready  output  1  rD bit is valid this cycle.

Behaviour:
- Reset (async, rstN=0): state=IDLE, rD=0, ready=0, shift and bit counters cleared. Memory contents are NOT cleared. Reset mid-transaction aborts it immediately.
- Control frame: 17 bits, one per cycle, MSB first: START(1) | SLAVE_ID[1:0] | rdWr (1=write, 0=read) | burst | address[11:0].
- IDLE: control=1 is taken as START; the next cycle enters RX_CTRL.
- RX_CTRL: shift 16 bits, counter 0..15. After the last address bit:
  - id mismatch -> IGNORE;
  - write -> WRITE;
  - read -> READ_FETCH.
- IGNORE: assert nothing; ignore valid, wrD and last. Return to IDLE on the first cycle where control=0 after frame end. Control stays low between frames, guaranteed by the master.
- WRITE: on each cycle with valid=1, shift wrD into a 16-bit register and increment the bit counter.
  - 16th valid bit: write the word to mem[addr] in the same edge, then addr=addr+1 modulo MEMORY_DEPTH (wraps from 4095 to 0).
  - Single (burst=0): go to IDLE after the first word; last is ignored.
  - Burst: go to IDLE when last=1 is sampled with the 16th bit.
  - last=1 with valid on any non-16th bit: discard the partial word, go to IDLE.
  - valid=0 cycles stall the shift; no timeout.
- READ_FETCH: 1 cycle for the synchronous memory read (latency 1), then load the shift register and go to READ_SEND.
- READ_SEND: ready=1 for exactly 16 consecutive cycles, with rD=word[15] first.
  - After bit 0: single -> IDLE.
  - Burst: addr+1 (wrap), then READ_FETCH, which gives one ready=0 gap cycle between words.
  - A burst read ends after the current word if last=1 was sampled at any cycle during that word.
- ready and rD are registered. rD=0 whenever ready=0.
- control=1 in any state other than IDLE/IGNORE is ignored (no re-start mid-transaction).
- Frame-to-first-read-bit latency: 2 cycles after the last address bit.

Decomposition:
- Package serial_bus_pkg:
  - state enum slave_state_t {IDLE, RX_CTRL, IGNORE, WRITE, READ_FETCH, READ_SEND};
  - constants CTRL_LEN=17, ID_WIDTH=2, RW_WRITE=1'b1;
  - frame field offsets.
- Sub-module slave_memory:
  - single-port synchronous RAM with write enable;
  - read latency 1;
  - parameters DATA_WIDTH and MEMORY_DEPTH.
- The FSM, shift registers and counters stay in bus_slave.

Test Plan:
1. Single write, then single read (SLAVE_ID=1): frame id=01, wr, burst=0, addr=5; write 16'hA5C3; read addr=5 -> ready high 16 cycles with rD=1010010111000011, returning 2 cycles after the frame; ready=0 afterwards.
2. Burst write with wrap: addr=4094, words 16'h0011, 16'h0022, 16'h0033, last on the 3rd word's 16th bit. Burst read from 4094, last during the 3rd word -> same 3 words in order, each separated by one ready=0 cycle, addr 0 holds 16'h0033.
3. ID mismatch: frame with id=10, write of 16'hFFFF to addr=5 with valid pulsed -> ready never asserts, mem[5] stays 16'hA5C3 on re-read.
4. Early last: burst write to addr=7 with last asserted on bit 8 of the first word -> mem[7] unchanged, next frame accepted normally.
5. valid stalls: single write of 16'h8001 with valid low for 3 cycles between bits 4 and 5 -> mem[addr] = 16'h8001.
6. Reset mid-read: drop rstN during bit 6 of READ_SEND -> ready=0 and rD=0 immediately (asynchronously); after release, the next read of the same address returns the original data.

Source files
------------

// File: rtl/serial_bus_pkg.sv
// Shared definitions for the serial bus slave: FSM states, control frame layout.
package serial_bus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RX_CTRL,
    IGNORE,
    WRITE,
    READ_FETCH,
    READ_SEND
  } slave_state_t;

  localparam int   CTRL_LEN   = 17;
  localparam int   ID_WIDTH   = 2;
  localparam logic RW_WRITE   = 1'b1;

  // Field offsets within the 16 bits that follow START.
  localparam int FRAME_BITS = CTRL_LEN - 1;
  localparam int ID_MSB     = 15;
  localparam int ID_LSB     = 14;
  localparam int RW_POS     = 13;
  localparam int BURST_POS  = 12;

  function automatic logic [ID_WIDTH-1:0] frame_id(input logic [FRAME_BITS-1:0] frame);
    return frame[ID_MSB:ID_LSB];
  endfunction

endpackage

// File: rtl/slave_memory.sv
// Single-port word memory, synchronous read with one cycle latency, read-before-write.
module slave_memory #(
  parameter int DATA_WIDTH    = 16,
  parameter int MEMORY_DEPTH  = 4096,
  parameter int ADDRESS_WIDTH = $clog2(MEMORY_DEPTH)
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [ADDRESS_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0]    wdata,
  output logic [DATA_WIDTH-1:0]    rdata
);

  logic [DATA_WIDTH-1:0] mem [MEMORY_DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/bus_slave.sv
// Serial bus slave endpoint: decodes the control frame, runs single/burst
// writes and reads against a local word memory.
//
// state      | meaning
// IDLE       | waiting for START on control
// RX_CTRL    | shifting in id, rdWr, burst and address
// IGNORE     | frame addressed elsewhere, wait for control low
// WRITE      | shifting in write words on valid
// READ_FETCH | memory read in flight, load shifter on exit
// READ_SEND  | driving 16 bits on rD with ready high
module bus_slave
  import serial_bus_pkg::*;
#(
  parameter logic [ID_WIDTH-1:0] SLAVE_ID      = 2'b01,
  parameter int                  DATA_WIDTH    = 16,
  parameter int                  MEMORY_DEPTH  = 4096,
  parameter int                  ADDRESS_WIDTH = $clog2(MEMORY_DEPTH)
) (
  input  logic clk,
  input  logic rstN,
  input  logic control,
  input  logic wrD,
  input  logic valid,
  input  logic last,
  output logic rD,
  output logic ready
);

  localparam int CNT_W = $clog2((DATA_WIDTH > FRAME_BITS) ? DATA_WIDTH : FRAME_BITS);
  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_BITS - 1);
  localparam logic [CNT_W-1:0] WORD_LAST  = CNT_W'(DATA_WIDTH - 1);
  localparam logic [ADDRESS_WIDTH-1:0] ADDR_TOP = ADDRESS_WIDTH'(MEMORY_DEPTH - 1);

  slave_state_t state_q, state_d;

  logic [FRAME_BITS-2:0]    ctrl_sr_q;
  logic [CNT_W-1:0]         cnt_q;
  logic [DATA_WIDTH-1:0]    data_sr_q;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic                     burst_q;
  logic                     last_seen_q;
  logic                     ready_q;
  logic                     rd_q;

  logic [FRAME_BITS-1:0]    frame;
  logic [ADDRESS_WIDTH-1:0] frame_addr;
  logic [ADDRESS_WIDTH-1:0] addr_nxt;
  logic [ADDRESS_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0]    word_in;
  logic [DATA_WIDTH-1:0]    mem_rdata;
  logic                     bit_last;
  logic                     mem_we;

  assign frame      = {ctrl_sr_q, control};
  assign frame_addr = frame[ADDRESS_WIDTH-1:0];
  assign addr_nxt   = (addr_q == ADDR_TOP) ? '0 : addr_q + 1'b1;
  assign word_in    = {data_sr_q[DATA_WIDTH-2:0], wrD};
  assign bit_last   = (cnt_q == WORD_LAST);
  assign mem_we     = (state_q == WRITE) && valid && bit_last;

  slave_memory #(
    .DATA_WIDTH   (DATA_WIDTH),
    .MEMORY_DEPTH (MEMORY_DEPTH),
    .ADDRESS_WIDTH(ADDRESS_WIDTH)
  ) u_mem (
    .clk  (clk),
    .we   (mem_we),
    .addr (mem_addr),
    .wdata(word_in),
    .rdata(mem_rdata)
  );

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // The memory is addressed with the upcoming address so the read issued on
  // the edge entering READ_FETCH is ready when READ_FETCH exits.
  always_comb begin
    state_d  = state_q;
    mem_addr = addr_q;
    case (state_q)
      IDLE: begin
        if (control) state_d = RX_CTRL;
      end
      RX_CTRL: begin
        if (cnt_q == FRAME_LAST) begin
          mem_addr = frame_addr;
          if (frame_id(frame) != SLAVE_ID) state_d = IGNORE;
          else if (frame[RW_POS] == RW_WRITE) state_d = WRITE;
          else state_d = READ_FETCH;
        end
      end
      IGNORE: begin
        if (!control) state_d = IDLE;
      end
      WRITE: begin
        if (valid) begin
          if (bit_last) begin
            if (!burst_q || last) state_d = IDLE;
          end else if (last) begin
            state_d = IDLE;
          end
        end
      end
      READ_FETCH: begin
        state_d = READ_SEND;
      end
      READ_SEND: begin
        if (bit_last) begin
          if (!burst_q || last_seen_q || last) begin
            state_d = IDLE;
          end else begin
            state_d  = READ_FETCH;
            mem_addr = addr_nxt;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      ctrl_sr_q   <= '0;
      cnt_q       <= '0;
      data_sr_q   <= '0;
      addr_q      <= '0;
      burst_q     <= 1'b0;
      last_seen_q <= 1'b0;
      ready_q     <= 1'b0;
      rd_q        <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
        end
        RX_CTRL: begin
          ctrl_sr_q <= frame[FRAME_BITS-2:0];
          if (cnt_q == FRAME_LAST) begin
            cnt_q   <= '0;
            addr_q  <= frame_addr;
            burst_q <= frame[BURST_POS];
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        WRITE: begin
          if (valid) begin
            data_sr_q <= word_in;
            if (bit_last) begin
              cnt_q  <= '0;
              addr_q <= addr_nxt;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        READ_FETCH: begin
          data_sr_q   <= mem_rdata;
          rd_q        <= mem_rdata[DATA_WIDTH-1];
          ready_q     <= 1'b1;
          cnt_q       <= '0;
          last_seen_q <= 1'b0;
        end
        READ_SEND: begin
          data_sr_q   <= data_sr_q << 1;
          last_seen_q <= last_seen_q | last;
          if (bit_last) begin
            ready_q <= 1'b0;
            rd_q    <= 1'b0;
            cnt_q   <= '0;
            if (state_d == READ_FETCH) addr_q <= addr_nxt;
          end else begin
            rd_q  <= data_sr_q[DATA_WIDTH-2];
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign rD    = rd_q;
  assign ready = ready_q;

endmodule

// File: tb/tb_bus_slave.sv
// Self-checking bench for bus_slave: directed scenarios plus randomized
// write/read-back traffic against a cycle-scheduled reference of the rD/ready stream.
module tb_bus_slave;

  localparam logic [1:0] SID = 2'b01;

  logic clk = 1'b0;
  logic rstN, control, wrD, valid, last;
  logic rD, ready;

  bus_slave #(.SLAVE_ID(SID)) dut (
    .clk    (clk),
    .rstN   (rstN),
    .control(control),
    .wrD    (wrD),
    .valid  (valid),
    .last   (last),
    .rD     (rD),
    .ready  (ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem_model [4096];
  bit          known     [4096];
  bit          exp_bit   [int];
  logic [15:0] got_q [$];
  logic [15:0] cap;
  int          capn = 0;
  int          first_rdy = -1;
  bit          arm = 0;
  logic [15:0] wbuf [8];
  int          wn;
  int          last_n;
  bit          er, ed;

  // Stream compare: ready/rD must follow the schedule built by the read tasks.
  always @(negedge clk) begin
    if (rstN === 1'b1) begin
      er = exp_bit.exists(cyc);
      ed = er ? exp_bit[cyc] : 1'b0;
      checks++;
      if (ready !== er || rD !== ed) begin
        errors++;
        $display("FAIL stream cyc=%0d ready=%b rD=%b expected ready=%b rD=%b", cyc, ready, rD, er, ed);
      end
      if (ready === 1'b1) begin
        if (arm) begin first_rdy = cyc; arm = 0; end
        cap = {cap[14:0], rD};
        capn++;
        if (capn == 16) begin got_q.push_back(cap); capn = 0; end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic expect_word(input string name, input logic [15:0] want);
    if (got_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s got=none want=%h", name, want);
    end else begin
      chk(name, got_q.pop_front(), want);
    end
  endtask

  task automatic send_frame(input logic [1:0] id, input logic rw, input logic brst,
                            input logic [11:0] addr, output int n);
    logic [15:0] f;
    f = {id, rw, brst, addr};
    n = cyc;
    control = 1'b1;
    tick();
    for (int k = 15; k >= 0; k--) begin
      control = f[k];
      tick();
    end
    control = 1'b0;
  endtask

  // Writes wbuf[0..wn-1]; early>0 raises last with the early-th bit of word 0.
  task automatic do_write(input logic [1:0] id, input logic brst, input logic [11:0] addr,
                          input int early, input int stall_at, input bit rnd_stall);
    int n, ns;
    logic [11:0] a;
    bit aborted;
    a = addr;
    aborted = 0;
    send_frame(id, 1'b1, brst, addr, n);
    for (int w = 0; w < wn && !aborted; w++) begin
      for (int b = 15; b >= 0 && !aborted; b--) begin
        ns = 0;
        if (stall_at == 16 - b) ns = 3;
        else if (rnd_stall && $urandom_range(0, 3) == 0) ns = $urandom_range(1, 2);
        for (int s = 0; s < ns; s++) begin
          valid = 1'b0; last = 1'b0; wrD = 1'($urandom_range(0, 1));
          tick();
        end
        valid = 1'b1;
        wrD   = wbuf[w][b];
        last  = (brst && w == wn - 1 && b == 0) || (early != 0 && w == 0 && early == 16 - b);
        tick();
        if (early != 0 && w == 0 && early == 16 - b) aborted = 1;
      end
      if (!aborted) begin
        if (id == SID) begin
          mem_model[a] = wbuf[w];
          known[a] = 1;
        end
        a = a + 12'd1;
        if (!brst) break;
      end
    end
    valid = 1'b0; last = 1'b0; wrD = 1'b0;
    tick();
    tick();
  endtask

  // Reads nw words; first bit is due two cycles after the last address bit,
  // words are separated by one idle cycle. rst_bit>=0 resets during that bit.
  task automatic do_read(input logic [1:0] id, input logic brst, input logic [11:0] addr,
                         input int nw, input int last_off, input int rst_bit);
    int n, s0, stop;
    bit done;
    got_q.delete();
    capn = 0;
    done = 0;
    send_frame(id, 1'b0, brst, addr, n);
    last_n = n;
    s0 = n + 18;
    if (id == SID)
      for (int w = 0; w < nw; w++)
        for (int i = 0; i < 16; i++)
          exp_bit[s0 + 17 * w + i] = mem_model[12'(addr + w)][15 - i];
    stop = s0 + 17 * nw + 2;
    while (cyc < stop && !done) begin
      last = brst && (cyc == s0 + 17 * (nw - 1) + last_off);
      if (rst_bit >= 0 && cyc == s0 + rst_bit) begin
        for (int c = cyc; c <= stop; c++)
          if (exp_bit.exists(c)) exp_bit.delete(c);
        last = 1'b0;
        #2;
        rstN = 1'b0;
        #1;
        chk("async_rst_ready", {15'b0, ready}, 16'h0);
        chk("async_rst_rD", {15'b0, rD}, 16'h0);
        tick();
        capn = 0;
        rstN = 1'b1;
        done = 1;
      end
      tick();
    end
    last = 1'b0;
    tick();
  endtask

  initial begin
    int a, nwr, nrd;
    logic [1:0] id;
    logic brst;
    control = 0; wrD = 0; valid = 0; last = 0;
    rstN = 1'b1;
    #1 rstN = 1'b0;
    #2;
    chk("reset_ready", {15'b0, ready}, 16'h0);
    chk("reset_rD", {15'b0, rD}, 16'h0);
    repeat (3) @(posedge clk);
    #1 rstN = 1'b1;
    tick();

    // single write then single read, latency pinned
    wn = 1; wbuf[0] = 16'hA5C3;
    do_write(SID, 1'b0, 12'd5, 0, 0, 0);
    arm = 1;
    do_read(SID, 1'b0, 12'd5, 1, 0, -1);
    chk("t1_latency", 16'(first_rdy - (last_n + 16)), 16'd2);
    expect_word("t1_word", 16'hA5C3);

    // burst write across the top of memory, burst read back
    wn = 3; wbuf[0] = 16'h0011; wbuf[1] = 16'h0022; wbuf[2] = 16'h0033;
    do_write(SID, 1'b1, 12'd4094, 0, 0, 0);
    do_read(SID, 1'b1, 12'd4094, 3, $urandom_range(0, 15), -1);
    expect_word("t2_w0", 16'h0011);
    expect_word("t2_w1", 16'h0022);
    expect_word("t2_w2", 16'h0033);
    do_read(SID, 1'b0, 12'd0, 1, 0, -1);
    expect_word("t2_addr0", 16'h0033);

    // other slave's frame must be ignored
    wn = 1; wbuf[0] = 16'hFFFF;
    do_write(2'b10, 1'b0, 12'd5, 0, 0, 1);
    do_read(2'b10, 1'b0, 12'd5, 1, 0, -1);
    do_read(SID, 1'b0, 12'd5, 1, 0, -1);
    expect_word("t3_mem5", 16'hA5C3);

    // early last discards the partial word
    wn = 1; wbuf[0] = 16'h1234;
    do_write(SID, 1'b0, 12'd7, 0, 0, 0);
    wbuf[0] = 16'hBEEF;
    do_write(SID, 1'b1, 12'd7, 8, 0, 0);
    do_read(SID, 1'b0, 12'd7, 1, 0, -1);
    expect_word("t4_mem7", 16'h1234);

    // valid stall between bits 4 and 5
    wn = 1; wbuf[0] = 16'h8001;
    do_write(SID, 1'b0, 12'd100, 0, 5, 0);
    do_read(SID, 1'b0, 12'd100, 1, 0, -1);
    expect_word("t5_stall", 16'h8001);

    // reset during bit 6 of a read
    do_read(SID, 1'b0, 12'd5, 1, 0, 6);
    do_read(SID, 1'b0, 12'd5, 1, 0, -1);
    expect_word("t6_after_rst", 16'hA5C3);

    // randomized traffic
    for (int it = 0; it < 40; it++) begin
      a   = $urandom_range(0, 4095);
      nwr = $urandom_range(1, 4);
      id  = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(2, 3)) : SID;
      brst = (nwr > 1) || ($urandom_range(0, 1) == 1);
      wn = brst ? nwr : 1;
      for (int w = 0; w < wn; w++) wbuf[w] = 16'($urandom());
      do_write(id, brst, 12'(a), 0, 0, 1);
      if (known[12'(a)]) begin
        nrd  = $urandom_range(1, wn);
        brst = (nrd > 1) || ($urandom_range(0, 1) == 1);
        for (int w = 0; w < nrd; w++)
          if (!known[12'(a + w)]) nrd = w;
        if (nrd > 0) do_read(SID, brst, 12'(a), nrd, $urandom_range(0, 15), -1);
      end else begin
        do_read(2'b00, 1'b0, 12'(a), 1, 0, -1);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
